// File: rtl/coletor_medidas.sv
// Acquisition sequencer: three triggered sensor readings with per-reading timeout,
// delivered as one triple. Optional retry-on-timeout enabled by define COLETOR_RETRY_EN.
module coletor_medidas #(
  parameter int unsigned INTERVALO = 1000,
  parameter int unsigned TIMEOUT   = 5000
) (
  input  logic        clock,
  input  logic        zera,
  input  logic        medir,
  input  logic [11:0] dado,
  input  logic        dado_pronto,
  output logic        disparo,
  output logic [11:0] medida1,
  output logic [11:0] medida2,
  output logic [11:0] medida3,
  output logic        iniciar,
  output logic        ocupado,
  output logic        erro_timeout,
  output logic [2:0]  estado
);

  typedef enum logic [2:0] {
    ST_OCIOSO    = 3'd0,
    ST_DISPARA   = 3'd1,
    ST_ESPERA    = 3'd2,
    ST_INTERVALO = 3'd3,
    ST_ENTREGA   = 3'd4,
    ST_ERRO      = 3'd5
  } estado_t;

  localparam logic [19:0] ULT_INTERVALO = 20'(INTERVALO - 1);
  localparam logic [19:0] ULT_TIMEOUT   = 20'(TIMEOUT - 1);

  estado_t     atual;
  estado_t     proximo;
  logic [19:0] contador;
  logic [1:0]  indice;
  logic [11:0] sombra0;
  logic [11:0] sombra1;
  logic        fim_timeout;
  logic        fim_intervalo;
`ifdef COLETOR_RETRY_EN
  logic        repete;
`endif

  assign fim_timeout   = (contador == ULT_TIMEOUT);
  assign fim_intervalo = (contador == ULT_INTERVALO);

  always_ff @(posedge clock) begin
    if (zera) atual <= ST_OCIOSO;
    else      atual <= proximo;
  end

  always_comb begin
    proximo = atual;
    case (atual)
      ST_OCIOSO:    if (medir) proximo = ST_DISPARA;
      ST_DISPARA:   proximo = ST_ESPERA;
      ST_ESPERA: begin
        if (dado_pronto) begin
          proximo = (indice == 2'd2) ? ST_ENTREGA : ST_INTERVALO;
        end else if (fim_timeout) begin
`ifdef COLETOR_RETRY_EN
          proximo = repete ? ST_ERRO : ST_DISPARA;
`else
          proximo = ST_ERRO;
`endif
        end
      end
      ST_INTERVALO: if (fim_intervalo) proximo = ST_DISPARA;
      ST_ENTREGA:   proximo = ST_OCIOSO;
      ST_ERRO:      if (medir) proximo = ST_DISPARA;
      default:      proximo = ST_OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (zera) begin
      contador <= '0;
      indice   <= '0;
      sombra0  <= '0;
      sombra1  <= '0;
      medida1  <= '0;
      medida2  <= '0;
      medida3  <= '0;
`ifdef COLETOR_RETRY_EN
      repete   <= 1'b0;
`endif
    end else begin
      case (atual)
        ST_OCIOSO: begin
          indice <= '0;
`ifdef COLETOR_RETRY_EN
          repete <= 1'b0;
`endif
        end
        ST_DISPARA: contador <= '0;
        ST_ESPERA: begin
          if (dado_pronto) begin
            indice   <= indice + 2'd1;
            contador <= '0;
`ifdef COLETOR_RETRY_EN
            repete   <= 1'b0;
`endif
            case (indice)
              2'd0: sombra0 <= dado;
              2'd1: sombra1 <= dado;
              default: begin
                // Third slot bypasses its shadow so the triple lands on the ENTREGA-entry edge.
                medida1 <= sombra0;
                medida2 <= sombra1;
                medida3 <= dado;
              end
            endcase
          end else begin
            contador <= contador + 20'd1;
`ifdef COLETOR_RETRY_EN
            if (fim_timeout) repete <= 1'b1;
`endif
          end
        end
        ST_INTERVALO: contador <= contador + 20'd1;
        ST_ERRO: begin
          if (medir) begin
            indice <= '0;
`ifdef COLETOR_RETRY_EN
            repete <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign disparo      = (atual == ST_DISPARA);
  assign iniciar      = (atual == ST_ENTREGA);
  assign ocupado      = (atual != ST_OCIOSO) && (atual != ST_ERRO);
  assign erro_timeout = (atual == ST_ERRO);
  assign estado       = atual;

endmodule

// File: tb/tb_coletor_medidas.sv
// Directed self-checking bench for coletor_medidas (INTERVALO=4, TIMEOUT=8).
module tb_coletor_medidas;

  logic        clock = 1'b0;
  logic        zera;
  logic        medir;
  logic [11:0] dado;
  logic        dado_pronto;
  logic        disparo;
  logic [11:0] medida1;
  logic [11:0] medida2;
  logic [11:0] medida3;
  logic        iniciar;
  logic        ocupado;
  logic        erro_timeout;
  logic [2:0]  estado;

  int erros   = 0;
  int checks  = 0;
  int n_disparo = 0;
  int n_iniciar = 0;

  coletor_medidas #(.INTERVALO(4), .TIMEOUT(8)) dut (
    .clock(clock), .zera(zera), .medir(medir), .dado(dado), .dado_pronto(dado_pronto),
    .disparo(disparo), .medida1(medida1), .medida2(medida2), .medida3(medida3),
    .iniciar(iniciar), .ocupado(ocupado), .erro_timeout(erro_timeout), .estado(estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (disparo) n_disparo++;
    if (iniciar) n_iniciar++;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      erros++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until disparo is high; returns the number of cycles waited.
  task automatic espera_disparo(output int n);
    n = 0;
    while (disparo !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) verifica("wait_disparo", 32'd0, 32'd1);
  endtask

  // Called in a DISPARA cycle; strobes v in ESPERA cycle k.
  task automatic captura(input int k, input logic [11:0] v);
    tick();
    for (int i = 1; i < k; i++) tick();
    dado_pronto = 1'b1;
    dado        = v;
    tick();
    dado_pronto = 1'b0;
  endtask

  task automatic confere_reset(input string pfx);
    verifica({pfx, "_estado"},  32'(estado),       32'd0);
    verifica({pfx, "_disparo"}, 32'(disparo),      32'd0);
    verifica({pfx, "_iniciar"}, 32'(iniciar),      32'd0);
    verifica({pfx, "_ocupado"}, 32'(ocupado),      32'd0);
    verifica({pfx, "_erro"},    32'(erro_timeout), 32'd0);
    verifica({pfx, "_m1"},      32'(medida1),      32'd0);
    verifica({pfx, "_m2"},      32'(medida2),      32'd0);
    verifica({pfx, "_m3"},      32'(medida3),      32'd0);
  endtask

  initial begin
    int n;
    int d0;
    int i0;
    zera = 1'b1; medir = 1'b0; dado = '0; dado_pronto = 1'b0;
    tick(); tick();
    zera = 1'b0;
    confere_reset("rst");

    // Round 1: strobes in ESPERA cycle 2, spurious strobe during INTERVALO
    d0 = n_disparo; i0 = n_iniciar;
    medir = 1'b1; tick(); medir = 1'b0;
    verifica("r1_disparo", 32'(disparo), 32'd1);
    verifica("r1_estado",  32'(estado),  32'd1);
    verifica("r1_ocupado", 32'(ocupado), 32'd1);
    captura(2, 12'h100);
    verifica("r1_intervalo", 32'(estado), 32'd3);
    espera_disparo(n);
    verifica("r1_int_len", 32'(n), 32'd4);
    captura(2, 12'h102);
    dado_pronto = 1'b1; dado = 12'hFFF; tick(); dado_pronto = 1'b0;
    verifica("spurious_estado", 32'(estado), 32'd3);
    espera_disparo(n);
    verifica("r1_int_len2", 32'(n), 32'd3);
    captura(2, 12'h101);
    verifica("r1_iniciar", 32'(iniciar), 32'd1);
    verifica("r1_entrega", 32'(estado),  32'd4);
    verifica("r1_m1", 32'(medida1), 32'h100);
    verifica("r1_m2", 32'(medida2), 32'h102);
    verifica("r1_m3", 32'(medida3), 32'h101);
    tick();
    verifica("r1_ocioso",  32'(estado),  32'd0);
    verifica("r1_ocup0",   32'(ocupado), 32'd0);
    verifica("r1_inic0",   32'(iniciar), 32'd0);
    verifica("r1_m1_hold", 32'(medida1), 32'h100);
    verifica("r1_ndisp",   32'(n_disparo - d0), 32'd3);
    verifica("r1_ninic",   32'(n_iniciar - i0), 32'd1);

    // Round 2: medir held high, first strobe at the last legal ESPERA cycle
    d0 = n_disparo;
    medir = 1'b1; tick();
    verifica("r2_disparo", 32'(disparo), 32'd1);
    captura(8, 12'h200);
    verifica("r2_boundary", 32'(estado), 32'd3);
    verifica("r2_noerro",   32'(erro_timeout), 32'd0);
    espera_disparo(n);
    captura(1, 12'h201);
    espera_disparo(n);
    captura(1, 12'h202);
    verifica("r2_iniciar", 32'(iniciar), 32'd1);
    verifica("r2_m1", 32'(medida1), 32'h200);
    verifica("r2_m2", 32'(medida2), 32'h201);
    verifica("r2_m3", 32'(medida3), 32'h202);
    tick();
    verifica("r2_ocioso", 32'(estado), 32'd0);
    verifica("r2_ndisp",  32'(n_disparo - d0), 32'd3);
    tick();
    verifica("r2_restart", 32'(disparo), 32'd1);
    medir = 1'b0;

    // Round 3: no strobe for slot 1
    d0 = n_disparo;
    captura(1, 12'h300);
    espera_disparo(n);
    tick();
    n = 0;
    while (estado == 3'd2 && n < 20) begin
      n++;
      tick();
    end
    verifica("r3_espera_len", 32'(n), 32'd8);
`ifdef COLETOR_RETRY_EN
    verifica("r3_retry_disp", 32'(disparo), 32'd1);
    verifica("r3_retry_erro", 32'(erro_timeout), 32'd0);
    captura(1, 12'h0AB);
    espera_disparo(n);
    captura(1, 12'h0AC);
    verifica("r3_m1", 32'(medida1), 32'h300);
    verifica("r3_m2", 32'(medida2), 32'h0AB);
    verifica("r3_m3", 32'(medida3), 32'h0AC);
    verifica("r3_ndisp", 32'(n_disparo - d0), 32'd4);
    tick();
    verifica("r3_noerro", 32'(erro_timeout), 32'd0);
    medir = 1'b1; tick(); medir = 1'b0;
`else
    verifica("r3_erro_est", 32'(estado),       32'd5);
    verifica("r3_erro",     32'(erro_timeout), 32'd1);
    verifica("r3_ocup",     32'(ocupado),      32'd0);
    verifica("r3_m1_keep",  32'(medida1),      32'h200);
    verifica("r3_m2_keep",  32'(medida2),      32'h201);
    verifica("r3_m3_keep",  32'(medida3),      32'h202);
    medir = 1'b1; tick(); medir = 1'b0;
    verifica("r3_erro_clr", 32'(erro_timeout), 32'd0);
`endif
    verifica("r3_disp_next", 32'(disparo), 32'd1);

    // Reset in ESPERA of slot 2, then a clean round from slot 0
    captura(1, 12'h010);
    espera_disparo(n);
    captura(1, 12'h011);
    espera_disparo(n);
    tick();
    zera = 1'b1; tick(); zera = 1'b0;
    confere_reset("zera");
    medir = 1'b1; tick(); medir = 1'b0;
    captura(1, 12'h020);
    espera_disparo(n);
    captura(1, 12'h021);
    espera_disparo(n);
    captura(1, 12'h022);
    verifica("r4_iniciar", 32'(iniciar), 32'd1);
    verifica("r4_m1", 32'(medida1), 32'h020);
    verifica("r4_m2", 32'(medida2), 32'h021);
    verifica("r4_m3", 32'(medida3), 32'h022);

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
